// File: rtl/enet_clk_ctrl_if.sv
// Speed-request handshake between PHY-management logic (master) and the
// Ethernet clock sequencer (slave).
interface enet_clk_ctrl_if;
    logic [1:0] speed_req;
    logic       speed_req_valid;
    logic       speed_req_ready;
    logic       speed_done;
    logic       speed_err;

    modport master (
        output speed_req,
        output speed_req_valid,
        input  speed_req_ready,
        input  speed_done,
        input  speed_err
    );

    modport slave (
        input  speed_req,
        input  speed_req_valid,
        output speed_req_ready,
        output speed_done,
        output speed_err
    );
endinterface

// File: rtl/enet_clk_ctrl.sv
// Ethernet clock PLL startup, MAC tx-clock speed switching and lock-loss recovery.
//   state       | meaning
//   S_PLL_RST   | PLL held in reset, MAC in reset
//   S_WAIT_LOCK | PLL released, waiting for lock (with timeout)
//   S_STABLE    | counting consecutive lock cycles
//   S_RUN       | clocks valid, MAC released, requests accepted
//   S_QUIESCE   | MAC held in reset before clock select changes
//   S_SWITCH    | clock select updated
//   S_SETTLE    | clocks settling after select change
module enet_clk_ctrl #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned QUIESCE_CYCLES      = 64,
    parameter int unsigned SETTLE_CYCLES       = 64,
    parameter logic [1:0]  DEFAULT_SPEED       = 2'b10
) (
    input  logic                 i_refclk,
    input  logic                 i_rst,
    enet_clk_ctrl_if.slave       s_req,
    input  logic                 i_pll_locked,
    output logic                 o_pll_rst,
    output logic                 o_mac_rst,
    output logic [1:0]           o_clk_sel,
    output logic                 o_clk_ok,
    output logic [7:0]           o_lock_loss_cnt
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_ABC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_DE  = (QUIESCE_CYCLES > SETTLE_CYCLES) ? QUIESCE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_ABC > MAX_DE) ? MAX_ABC : MAX_DE;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_QUIESCE,
        S_SWITCH,
        S_SETTLE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_sync1;
    logic            r_lock_s;
    logic            r_pll_rst;
    logic            r_mac_rst;
    logic [1:0]      r_clk_sel;
    logic            r_clk_ok;
    logic            r_done;
    logic            r_err;
    logic [7:0]      r_llc;
    logic [1:0]      r_pend_sel;
    logic            r_pend;

    logic            w_ready;
    logic            w_accept;
    logic            w_cnt_zero;
    logic            w_lost;
    logic [7:0]      w_llc_next;

    assign w_ready    = (r_state == S_RUN) && r_lock_s;
    assign w_accept   = s_req.speed_req_valid && w_ready;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_lost     = !r_lock_s && ((r_state == S_RUN) || (r_state == S_QUIESCE) ||
                                      (r_state == S_SWITCH) || (r_state == S_SETTLE));
    assign w_llc_next = (r_llc == 8'hFF) ? r_llc : r_llc + 8'd1;

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state    <= S_PLL_RST;
            r_cnt      <= CW'(PLL_RST_CYCLES - 1);
            r_sync1    <= 1'b0;
            r_lock_s   <= 1'b0;
            r_pll_rst  <= 1'b1;
            r_mac_rst  <= 1'b1;
            r_clk_sel  <= DEFAULT_SPEED;
            r_clk_ok   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_llc      <= 8'd0;
            r_pend_sel <= DEFAULT_SPEED;
            r_pend     <= 1'b0;
        end else begin
            r_sync1  <= i_pll_locked;
            r_lock_s <= r_sync1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= r_cnt - CW'(1);

            if (w_lost) begin
                // A pending switch still lands on the new select so re-lock resumes at the requested speed.
                if ((r_state == S_QUIESCE) || (r_state == S_SWITCH))
                    r_clk_sel <= r_pend_sel;
                r_state   <= S_PLL_RST;
                r_cnt     <= CW'(PLL_RST_CYCLES - 1);
                r_pll_rst <= 1'b1;
                r_mac_rst <= 1'b1;
                r_clk_ok  <= 1'b0;
                r_llc     <= w_llc_next;
            end else begin
                case (r_state)
                    S_PLL_RST: begin
                        if (w_cnt_zero) begin
                            r_state   <= S_WAIT_LOCK;
                            r_pll_rst <= 1'b0;
                            r_cnt     <= CW'(LOCK_TIMEOUT_CYCLES - 1);
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (r_lock_s) begin
                            r_state <= S_STABLE;
                            r_cnt   <= CW'(LOCK_STABLE_CYCLES);
                        end else if (w_cnt_zero) begin
                            r_state   <= S_PLL_RST;
                            r_pll_rst <= 1'b1;
                            r_cnt     <= CW'(PLL_RST_CYCLES - 1);
                        end
                    end
                    S_STABLE: begin
                        if (!r_lock_s) begin
                            r_state <= S_WAIT_LOCK;
                            r_cnt   <= CW'(LOCK_TIMEOUT_CYCLES - 1);
                        end else if (w_cnt_zero) begin
                            r_state   <= S_RUN;
                            r_mac_rst <= 1'b0;
                            r_clk_ok  <= 1'b1;
                            r_done    <= r_pend;
                            r_pend    <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (w_accept) begin
                            if (s_req.speed_req == 2'b11) begin
                                r_err <= 1'b1;
                            end else if (s_req.speed_req == r_clk_sel) begin
                                r_done <= 1'b1;
                            end else begin
                                r_pend_sel <= s_req.speed_req;
                                r_pend     <= 1'b1;
                                r_state    <= S_QUIESCE;
                                r_mac_rst  <= 1'b1;
                                r_clk_ok   <= 1'b0;
                                r_cnt      <= CW'(QUIESCE_CYCLES - 1);
                            end
                        end
                    end
                    S_QUIESCE: begin
                        if (w_cnt_zero)
                            r_state <= S_SWITCH;
                    end
                    S_SWITCH: begin
                        r_clk_sel <= r_pend_sel;
                        r_state   <= S_SETTLE;
                        r_cnt     <= CW'(SETTLE_CYCLES);
                    end
                    S_SETTLE: begin
                        if (w_cnt_zero) begin
                            r_state   <= S_RUN;
                            r_mac_rst <= 1'b0;
                            r_clk_ok  <= 1'b1;
                            r_done    <= 1'b1;
                            r_pend    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_PLL_RST;
                    end
                endcase
            end
        end
    end

    assign s_req.speed_req_ready = w_ready;
    assign s_req.speed_done      = r_done;
    assign s_req.speed_err       = r_err;
    assign o_pll_rst             = r_pll_rst;
    assign o_mac_rst             = r_mac_rst;
    assign o_clk_sel             = r_clk_sel;
    assign o_clk_ok              = r_clk_ok;
    assign o_lock_loss_cnt       = r_llc;

endmodule

// File: tb/tb_enet_clk_ctrl.sv
// Self-checking bench for enet_clk_ctrl: per-scenario tasks plus a scoreboard
// that matches every speed_done / speed_err pulse against queued expectations.
module tb_enet_clk_ctrl;
    localparam int P_RST = 4;
    localparam int P_STB = 8;
    localparam int P_TO  = 32;
    localparam int P_Q   = 4;
    localparam int P_S   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, mac_rst, clk_ok;
    logic [1:0] clk_sel;
    logic [7:0] llc;

    enet_clk_ctrl_if bus();

    enet_clk_ctrl #(
        .PLL_RST_CYCLES(P_RST),
        .LOCK_STABLE_CYCLES(P_STB),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .QUIESCE_CYCLES(P_Q),
        .SETTLE_CYCLES(P_S),
        .DEFAULT_SPEED(2'b10)
    ) dut (
        .i_refclk(clk),
        .i_rst(rst),
        .s_req(bus.slave),
        .i_pll_locked(pll_locked),
        .o_pll_rst(pll_rst),
        .o_mac_rst(mac_rst),
        .o_clk_sel(clk_sel),
        .o_clk_ok(clk_ok),
        .o_lock_loss_cnt(llc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [1:0] sel;
        int         exp_cyc;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] m_llc = 8'd0;
    logic [1:0] m_sel = 2'b10;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.speed_done || bus.speed_err) begin
            exp_t e;
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: done=%0b err=%0b clk_sel=%b at cyc %0d, required no pulse",
                         bus.speed_done, bus.speed_err, clk_sel, cyc);
            end else begin
                e = sbq.pop_front();
                if (bus.speed_err !== e.is_err || bus.speed_done !== !e.is_err || clk_sel !== e.sel ||
                    (e.exp_cyc >= 0 && cyc != e.exp_cyc)) begin
                    failures++;
                    $display("FAIL sb_pulse: done=%0b err=%0b clk_sel=%b cyc=%0d, required err=%0b sel=%b cyc=%0d",
                             bus.speed_done, bus.speed_err, clk_sel, cyc, e.is_err, e.sel, e.exp_cyc);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.speed_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        sbq.delete();
        m_llc = 8'd0;
        m_sel = 2'b10;
        rst = 1'b0;
    endtask

    task automatic wait_run(input string name, input int budget);
        int n = 0;
        while (clk_ok !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (clk_ok !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s: clk_ok=%b after %0d cycles, required 1", name, clk_ok, budget);
        end
    endtask

    // Holds valid until ready; returns on the negedge right after the accepting edge.
    task automatic send_req(input logic [1:0] code, input int lat, input int budget);
        exp_t e;
        bit   acc = 0;
        int   n = 0;
        while (!acc && n < budget) begin
            @(negedge clk);
            bus.speed_req = code;
            bus.speed_req_valid = 1'b1;
            if (bus.speed_req_ready === 1'b1) begin
                e.is_err  = (code == 2'b11);
                e.sel     = (code == 2'b11) ? m_sel : code;
                e.exp_cyc = (lat < 0) ? -1 : cyc + 1 + lat;
                sbq.push_back(e);
                if (code != 2'b11) m_sel = code;
                acc = 1;
            end
            n++;
        end
        @(negedge clk);
        bus.speed_req_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_req_timeout: code=%b not accepted in %0d cycles, required accept", code, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        checks += 8;
        if (pll_rst !== 1'b1) begin failures++; $display("FAIL rst_pll_rst: got %b, required 1", pll_rst); end
        if (mac_rst !== 1'b1) begin failures++; $display("FAIL rst_mac_rst: got %b, required 1", mac_rst); end
        if (clk_sel !== 2'b10) begin failures++; $display("FAIL rst_clk_sel: got %b, required 10", clk_sel); end
        if (clk_ok !== 1'b0) begin failures++; $display("FAIL rst_clk_ok: got %b, required 0", clk_ok); end
        if (bus.speed_req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b, required 0", bus.speed_req_ready); end
        if (bus.speed_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b, required 0", bus.speed_done); end
        if (bus.speed_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b, required 0", bus.speed_err); end
        if (llc !== 8'd0) begin failures++; $display("FAIL rst_llc: got %0d, required 0", llc); end
    endtask

    task automatic test_cold_start();
        int pll_fall = -1;
        int mac_fall = -1;
        pll_locked = 1'b1;
        do_reset();
        for (int k = 1; k <= 40 && mac_fall < 0; k++) begin
            @(negedge clk);
            if (pll_fall < 0 && pll_rst === 1'b0) pll_fall = k;
            if (mac_fall < 0 && mac_rst === 1'b0) mac_fall = k;
        end
        checks += 4;
        if (pll_fall != P_RST) begin failures++; $display("FAIL cold_pll_rst_len: got %0d, required %0d", pll_fall, P_RST); end
        if (mac_fall < 14 || mac_fall > 16) begin failures++; $display("FAIL cold_latency: got %0d, required 14..16", mac_fall); end
        if (clk_ok !== 1'b1) begin failures++; $display("FAIL cold_clk_ok: got %b, required 1", clk_ok); end
        if (clk_sel !== 2'b10) begin failures++; $display("FAIL cold_clk_sel: got %b, required 10", clk_sel); end
    endtask

    task automatic test_same_and_reserved();
        int mac_hi = 0;
        send_req(2'b10, 0, 10);
        for (int k = 0; k < 4; k++) begin
            if (mac_rst !== 1'b0) mac_hi++;
            @(negedge clk);
        end
        send_req(2'b11, 0, 10);
        for (int k = 0; k < 4; k++) begin
            if (mac_rst !== 1'b0) mac_hi++;
            @(negedge clk);
        end
        checks += 2;
        if (mac_hi != 0) begin failures++; $display("FAIL same_mac_rst: high for %0d cycles, required 0", mac_hi); end
        if (clk_sel !== 2'b10) begin failures++; $display("FAIL reserved_clk_sel: got %b, required 10", clk_sel); end
    endtask

    task automatic test_speed_change();
        int         first_sel = -1;
        int         mac_hi = 0;
        int         bad_sel_chg = 0;
        logic [1:0] prev_sel;
        prev_sel = clk_sel;
        send_req(2'b01, P_Q + 1 + P_S + 1, 10);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            if (mac_rst === 1'b1) mac_hi++;
            if (first_sel < 0 && clk_sel === 2'b01) first_sel = k;
            if (clk_sel !== prev_sel && (mac_rst !== 1'b1 || clk_ok !== 1'b0)) bad_sel_chg++;
            prev_sel = clk_sel;
        end
        checks += 4;
        if (first_sel != P_Q + 1) begin failures++; $display("FAIL chg_sel_time: got %0d, required %0d", first_sel, P_Q + 1); end
        if (mac_hi != P_Q + 1 + P_S + 1) begin failures++; $display("FAIL chg_mac_rst_len: got %0d, required %0d", mac_hi, P_Q + P_S + 2); end
        if (bad_sel_chg != 0) begin failures++; $display("FAIL chg_sel_while_live: got %0d, required 0", bad_sel_chg); end
        if (clk_ok !== 1'b1) begin failures++; $display("FAIL chg_clk_ok: got %b, required 1", clk_ok); end
    endtask

    task automatic test_back_to_back();
        send_req(2'b00, P_Q + P_S + 2, 20);
        send_req(2'b10, P_Q + P_S + 2, 40);
        repeat (12) @(negedge clk);
        checks += 2;
        if (clk_sel !== 2'b10) begin failures++; $display("FAIL b2b_clk_sel: got %b, required 10", clk_sel); end
        if (sbq.size() != 0) begin failures++; $display("FAIL b2b_pending: got %0d entries, required 0", sbq.size()); end
    endtask

    task automatic test_lock_timeout();
        int fall[$];
        int rise[$];
        int mac_low = 0;
        logic prev;
        pll_locked = 1'b0;
        do_reset();
        prev = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (prev === 1'b1 && pll_rst === 1'b0) fall.push_back(k);
            if (prev === 1'b0 && pll_rst === 1'b1) rise.push_back(k);
            if (mac_rst !== 1'b1) mac_low++;
            prev = pll_rst;
        end
        checks += 3;
        if (fall.size() < 2 || fall[0] != P_RST || fall[1] != 2 * P_RST + P_TO) begin
            failures++;
            $display("FAIL to_pll_fall: got %0d falls first=%0d, required %0d and %0d",
                     fall.size(), (fall.size() > 0) ? fall[0] : -1, P_RST, 2 * P_RST + P_TO);
        end
        if (rise.size() < 2 || rise[0] != P_RST + P_TO || rise[1] - rise[0] != P_RST + P_TO) begin
            failures++;
            $display("FAIL to_pll_rise: got %0d rises first=%0d, required first=%0d period=%0d",
                     rise.size(), (rise.size() > 0) ? rise[0] : -1, P_RST + P_TO, P_RST + P_TO);
        end
        if (mac_low != 0) begin failures++; $display("FAIL to_mac_rst: low for %0d cycles, required 0", mac_low); end
        pll_locked = 1'b1;
        wait_run("to_relock", 80);
    endtask

    task automatic test_settle_drop();
        int n = 0;
        send_req(2'b00, -1, 10);
        repeat (P_Q + 1) @(negedge clk);
        pll_locked = 1'b0;
        while (pll_rst !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        m_llc = (m_llc == 8'hFF) ? m_llc : m_llc + 8'd1;
        checks += 4;
        if (pll_rst !== 1'b1) begin failures++; $display("FAIL settle_pll_rst: got %b, required 1", pll_rst); end
        if (llc !== m_llc) begin failures++; $display("FAIL settle_llc: got %0d, required %0d", llc, m_llc); end
        if (clk_sel !== 2'b00) begin failures++; $display("FAIL settle_clk_sel: got %b, required 00", clk_sel); end
        if (clk_ok !== 1'b0) begin failures++; $display("FAIL settle_clk_ok: got %b, required 0", clk_ok); end
        pll_locked = 1'b1;
        wait_run("settle_relock", 60);
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin failures++; $display("FAIL settle_done_missing: got %0d pending, required 0", sbq.size()); end
    endtask

    task automatic test_coincident();
        @(negedge clk);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        bus.speed_req = 2'b01;
        bus.speed_req_valid = 1'b1;
        checks++;
        if (bus.speed_req_ready !== 1'b0) begin failures++; $display("FAIL coinc_ready: got %b, required 0", bus.speed_req_ready); end
        @(negedge clk);
        m_llc = (m_llc == 8'hFF) ? m_llc : m_llc + 8'd1;
        checks += 3;
        if (pll_rst !== 1'b1) begin failures++; $display("FAIL coinc_pll_rst: got %b, required 1", pll_rst); end
        if (llc !== m_llc) begin failures++; $display("FAIL coinc_llc: got %0d, required %0d", llc, m_llc); end
        if (clk_sel !== m_sel) begin failures++; $display("FAIL coinc_clk_sel: got %b, required %b", clk_sel, m_sel); end
        pll_locked = 1'b1;
        send_req(2'b01, P_Q + P_S + 2, 100);
        repeat (12) @(negedge clk);
    endtask

    task automatic test_saturation();
        pll_locked = 1'b1;
        do_reset();
        wait_run("sat_start", 40);
        for (int i = 0; i < 300; i++) begin
            int n = 0;
            @(negedge clk);
            pll_locked = 1'b0;
            while (pll_rst !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            m_llc = (m_llc == 8'hFF) ? m_llc : m_llc + 8'd1;
            pll_locked = 1'b1;
            wait_run("sat_relock", 40);
            if (i == 9) begin
                checks++;
                if (llc !== m_llc) begin failures++; $display("FAIL sat_llc_10: got %0d, required %0d", llc, m_llc); end
            end
        end
        checks++;
        if (llc !== 8'd255) begin failures++; $display("FAIL sat_llc_255: got %0d, required 255", llc); end
    endtask

    task automatic test_rst_quiesce();
        send_req(2'b00, P_Q + P_S + 2, 10);
        repeat (12) @(negedge clk);
        send_req(2'b01, P_Q + P_S + 2, 10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (clk_sel !== 2'b10) begin failures++; $display("FAIL rstq_clk_sel: got %b, required 10", clk_sel); end
        if (mac_rst !== 1'b1) begin failures++; $display("FAIL rstq_mac_rst: got %b, required 1", mac_rst); end
        if (pll_rst !== 1'b1) begin failures++; $display("FAIL rstq_pll_rst: got %b, required 1", pll_rst); end
        if (clk_ok !== 1'b0) begin failures++; $display("FAIL rstq_clk_ok: got %b, required 0", clk_ok); end
        if (llc !== 8'd0) begin failures++; $display("FAIL rstq_llc: got %0d, required 0", llc); end
        sbq.delete();
        m_llc = 8'd0;
        m_sel = 2'b10;
        rst = 1'b0;
        wait_run("rstq_relock", 40);
        repeat (15) @(negedge clk);
        checks++;
        if (clk_sel !== 2'b10) begin failures++; $display("FAIL rstq_final_sel: got %b, required 10", clk_sel); end
    endtask

    initial begin
        bus.speed_req = 2'b00;
        bus.speed_req_valid = 1'b0;
        test_reset();
        test_cold_start();
        test_same_and_reserved();
        test_speed_change();
        test_back_to_back();
        test_lock_timeout();
        test_settle_drop();
        test_coincident();
        test_saturation();
        test_rst_quiesce();
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d entries, required 0", sbq.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/enet_clk_ctrl.md
# enet_clk_ctrl

Sequencer for the Ethernet clock PLL (125 / 25 / 2.5 MHz outputs) and the MAC transmit-clock selection. It runs on the PLL reference clock and controls the startup order:
- holds the PLL in reset, waits for a stable lock, then releases the MAC reset;
- performs link-speed changes (10/100/1000) by quiescing the MAC, switching the clock select and letting the clocks settle;
- recovers from lock loss.

It sits between the PLL wrapper, the external clock mux and the MAC reset, and takes speed requests from PHY-management software or logic.

## Interface
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per reset attempt (≥2).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (≥2).
- LOCK_TIMEOUT_CYCLES, 65536: cycles to wait for lock before a new reset attempt.
- QUIESCE_CYCLES, 64: MAC-reset hold before the clock select changes (≥1).
- SETTLE_CYCLES, 64: hold after the clock select changes (≥1).
- DEFAULT_SPEED, 2'b10: speed code after reset (00 = 10M/2.5 MHz, 01 = 100M/25 MHz, 10 = 1000M/125 MHz).

Ports:
- `refclk` in 1: single clock (50 MHz reference).
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL lock, asynchronous to `refclk`.
- `speed_req` in 2: requested speed code.
- `speed_req_valid` in 1: request valid.
- `speed_req_ready` out 1: request accepted when valid && ready.
- `speed_done` out 1: one-cycle pulse, the request has completed.
- `speed_err` out 1: one-cycle pulse, reserved code 2'b11 was rejected.
- `pll_rst` out 1: PLL reset.
- `mac_rst` out 1: MAC/datapath reset.
- `clk_sel` out 2: clock-mux select, equal to the current speed code.
- `clk_ok` out 1: clocks valid, high only in RUN.
- `lock_loss_cnt` out 8: saturating count of lock losses after the first release.

## Operation
- `pll_locked` passes through a 2-flop synchronizer → `lock_s`. All decisions use `lock_s` only.
- One shared down-counter, width = clog2 of the largest cycle parameter + 1.
- States: PLL_RST, WAIT_LOCK, STABLE, RUN, QUIESCE, SWITCH, SETTLE.
- **PLL_RST:** `pll_rst`=1, `mac_rst`=1. After PLL_RST_CYCLES → WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst`=0. If `lock_s`=1 → STABLE. If LOCK_TIMEOUT_CYCLES elapse without lock → PLL_RST (retry indefinitely).
- **STABLE:** needs LOCK_STABLE_CYCLES consecutive cycles of `lock_s`=1, then → RUN.
  - Any `lock_s`=0 → WAIT_LOCK with the timeout restarted.
- **RUN:** `mac_rst`=0, `clk_ok`=1. `speed_req_ready` = (state==RUN && `lock_s`), a combinational AND of registered terms.
  - On accept with code 11: `speed_err` pulses next cycle, no state change.
  - On accept with code equal to `clk_sel`: `speed_done` pulses next cycle, no state change.
  - On accept with any other code: latch it as the pending speed → QUIESCE.
  - `lock_s`=0: → PLL_RST and `lock_loss_cnt`+1, saturating at 255.
- **QUIESCE:** `mac_rst`=1, `clk_ok`=0 for QUIESCE_CYCLES, then → SWITCH.
- **SWITCH:** one cycle; `clk_sel` ← pending speed, then → SETTLE.
- **SETTLE:** SETTLE_CYCLES, then → RUN. `speed_done` pulses in the first RUN cycle.
- **Lock loss in QUIESCE/SWITCH/SETTLE:** → PLL_RST and `lock_loss_cnt`+1.
  - If the loss occurs in QUIESCE, `clk_sel` is updated to the pending speed on the same transition.
  - The request stays outstanding; `speed_done` pulses in the first RUN cycle after re-lock.
- **Boundary cases:**
  - Lock loss in the same cycle as `speed_req_valid` in RUN: lock loss wins. Ready is 0, the request is not accepted and the requester must hold it.
  - No second request is accepted until the outstanding one has completed (ready=0 outside RUN).

## Timing
- **Reset values:**
  - `pll_rst`=1, `mac_rst`=1
  - `clk_sel`=DEFAULT_SPEED
  - `clk_ok`=0, `speed_req_ready`=0
  - `speed_done`=0, `speed_err`=0
  - `lock_loss_cnt`=0
  - state = PLL_RST with the counter loaded.
- `rst` in any state returns to the reset values on the next edge. A speed change in progress is abandoned and `clk_sel` reverts to DEFAULT_SPEED.
- All outputs except `speed_req_ready` are registered.
- **Cold-start latency**, rst falling edge to `mac_rst` low, with lock present from the start: PLL_RST_CYCLES + 2 (sync) + 1 + LOCK_STABLE_CYCLES cycles, ±1.
- **Speed change latency**, accept edge to `speed_done`: QUIESCE_CYCLES + 1 + SETTLE_CYCLES + 1 cycles.
- `clk_sel` changes only while `mac_rst`=1 and `clk_ok`=0.
- `mac_rst` is asserted on the edge that leaves RUN.

## Test plan
Use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, QUIESCE_CYCLES=4, SETTLE_CYCLES=4.
- **Cold start:** `pll_locked`=1 from cycle 0 → `pll_rst` high 4 cycles; `mac_rst` falls and `clk_ok` rises ~15 cycles after reset release; `clk_sel`=10.
- **Lock timeout:** `pll_locked` held 0 → `pll_rst` re-pulses every 4+32 cycles; `mac_rst` stays 1.
- **Speed change 10→01 in RUN:** ready=1 at accept; `mac_rst`=1 for 10 cycles; `clk_sel`=01 after 5 cycles; `speed_done` pulse at +10.
- **Same-speed and reserved codes:** request 10 → `speed_done` next cycle, `mac_rst` stays 0. Request 11 → `speed_err` pulse, `clk_sel` unchanged.
- **Lock drop during SETTLE:** `lock_loss_cnt`=1, `pll_rst` pulses, new `clk_sel` is retained; `speed_done` pulses once, on re-entry into RUN.
- **Edge cases:** 300 lock drops saturate `lock_loss_cnt` at 255. Lock loss coincident with valid → request not accepted. `rst` asserted mid-QUIESCE → `clk_sel`=DEFAULT_SPEED and `mac_rst`=1 on the next edge.
